// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming(7,4) serial transmitter.
package hamming_pkg;

    localparam int CODE_W     = 7;
    localparam int FRAME_BITS = 9;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

endpackage

// File: rtl/hamming74_enc.sv
// Combinational Hamming(7,4) encoder; wire order {p0,p1,d0,p2,d1,d2,d3}.
module hamming74_enc
    import hamming_pkg::*;
(
    input  logic [3:0]        data_i,
    output logic [CODE_W-1:0] code_o
);

    logic p0;
    logic p1;
    logic p2;

    assign p0 = data_i[0] ^ data_i[1] ^ data_i[3];
    assign p1 = data_i[0] ^ data_i[2] ^ data_i[3];
    assign p2 = data_i[1] ^ data_i[2] ^ data_i[3];

    assign code_o = {p0, p1, data_i[0], p2, data_i[1], data_i[2], data_i[3]};

endmodule

// File: rtl/hamming_tx.sv
// Serial transmitter: accepts a nibble, sends start bit, 7-bit codeword
// (MSB first) and stop bit, each CLKS_PER_BIT cycles long.
module hamming_tx
    import hamming_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [3:0]        in_data,
    output logic              in_ready,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic [CODE_W-1:0] code_out,
    output logic              frame_done
);

    localparam logic [7:0] LAST_TICK = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT  = 3'(CODE_W - 1);

    state_t            state_q, state_d;
    logic [7:0]        tick_q, tick_d;
    logic [2:0]        bit_q, bit_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              serial_q, serial_d;
    logic [CODE_W-1:0] enc_code;
    logic              xfer;
    logic              tick_last;

    hamming74_enc u_enc (
        .data_i (in_data),
        .code_o (enc_code)
    );

    assign in_ready   = (state_q == IDLE);
    assign xfer       = in_valid && in_ready;
    assign tick_last  = (tick_q == LAST_TICK);
    assign tx_busy    = (state_q != IDLE);
    assign frame_done = (state_q == STOP) && tick_last;
    assign tx_serial  = serial_q;
    assign code_out   = code_q;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        code_d  = code_q;
        tick_d  = (state_q == IDLE || tick_last) ? 8'd0 : tick_q + 8'd1;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = START;
                    code_d  = enc_code;
                end
            end
            START: begin
                if (tick_last) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (tick_last) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick_last) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                bit_d   = 3'd0;
            end
        endcase
    end

    // Line level is derived from the next state so the output is a flop.
    always_comb begin
        serial_d = 1'b1;
        unique case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = code_d[LAST_BIT - bit_d];
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tick_q   <= 8'd0;
            bit_q    <= 3'd0;
            code_q   <= '0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            code_q   <= code_d;
            serial_q <= serial_d;
        end
    end

endmodule
